// File: rtl/idma_lite_mem_responder.sv
// AXI-Lite subordinate with a byte-strobed word memory; B two cycles after AW+W, R ReadLatency cycles after AR.
// Write holds stall while B is unaccepted; reads are one at a time. IDMA_LITE_MEM_RANGE_CHECK_EN enables SLVERR on out-of-range addresses.
module idma_lite_mem_responder #(
    parameter int                   DataWidth   = 32,
    parameter int                   AddrWidth   = 32,
    parameter int                   NumWords    = 256,
    parameter logic [AddrWidth-1:0] BaseAddr    = '0,
    parameter int                   ReadLatency = 1,
    parameter int                   StrbWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [2:0]           aw_prot_i,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [DataWidth-1:0] w_data_i,
    input  logic [StrbWidth-1:0] w_strb_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    output logic [1:0]           b_resp_o,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [2:0]           ar_prot_i,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_valid_o,
    input  logic                 r_ready_i
);
    localparam int OffW = $clog2(StrbWidth);
    localparam int IdxW = $clog2(NumWords);
    localparam int CntW = $clog2(ReadLatency + 1);
    localparam logic [AddrWidth:0] SpanBytes = (AddrWidth + 1)'(NumWords * StrbWidth);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_RESP} rd_state_t;

    logic [DataWidth-1:0] mem [NumWords];

    logic [AddrWidth-1:0] aw_off, ar_off;
    logic                 aw_in, ar_in;

    assign aw_off = aw_addr_i - BaseAddr;
    assign ar_off = ar_addr_i - BaseAddr;

`ifdef IDMA_LITE_MEM_RANGE_CHECK_EN
    assign aw_in = (aw_addr_i >= BaseAddr) && ({1'b0, aw_off} < SpanBytes);
    assign ar_in = (ar_addr_i >= BaseAddr) && ({1'b0, ar_off} < SpanBytes);
`else
    // Without the check the index simply wraps inside the memory.
    assign aw_in = 1'b1;
    assign ar_in = 1'b1;
`endif

    logic unused_bits;
    assign unused_bits = ^{aw_prot_i, ar_prot_i, aw_off, ar_off, SpanBytes};

    // Write path
    logic                 aw_full, w_full, aw_ok_q;
    logic [IdxW-1:0]      aw_idx_q;
    logic [DataWidth-1:0] w_data_q;
    logic [StrbWidth-1:0] w_strb_q;
    logic                 b_valid_q;
    logic [1:0]           b_resp_q;
    logic                 commit;

    assign commit     = aw_full & w_full & (~b_valid_q | b_ready_i);
    assign aw_ready_o = ~aw_full | commit;
    assign w_ready_o  = ~w_full | commit;
    assign b_valid_o  = b_valid_q;
    assign b_resp_o   = b_resp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_full   <= 1'b0;
            aw_ok_q   <= 1'b0;
            aw_idx_q  <= '0;
            w_full    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_valid_q <= 1'b0;
            b_resp_q  <= RespOkay;
        end else begin
            if (aw_valid_i && aw_ready_o) begin
                aw_full  <= 1'b1;
                aw_idx_q <= aw_off[OffW +: IdxW];
                aw_ok_q  <= aw_in;
            end else if (commit) begin
                aw_full <= 1'b0;
            end
            if (w_valid_i && w_ready_o) begin
                w_full   <= 1'b1;
                w_data_q <= w_data_i;
                w_strb_q <= w_strb_i;
            end else if (commit) begin
                w_full <= 1'b0;
            end
            if (commit) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= aw_ok_q ? RespOkay : RespSlvErr;
            end else if (b_ready_i) begin
                b_valid_q <= 1'b0;
            end
        end
    end

    // Memory array carries no reset; contents are undefined until written.
    always_ff @(posedge clk_i) begin
        if (commit && aw_ok_q) begin
            for (int b = 0; b < StrbWidth; b++) begin
                if (w_strb_q[b]) mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
            end
        end
    end

    // Read path
    rd_state_t            rd_state;
    logic [CntW-1:0]      rd_cnt;
    logic [DataWidth-1:0] r_data_q;
    logic [1:0]           r_resp_q;
    logic                 r_valid_q, ar_ready_q;

    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_data_o   = r_data_q;
    assign r_resp_o   = r_resp_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state   <= RD_IDLE;
            rd_cnt     <= '0;
            r_data_q   <= '0;
            r_resp_q   <= RespOkay;
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_valid_i) begin
                        // Sampled before this edge's commit lands, so same-word reads see old data.
                        r_data_q   <= ar_in ? mem[ar_off[OffW +: IdxW]] : '0;
                        r_resp_q   <= ar_in ? RespOkay : RespSlvErr;
                        ar_ready_q <= 1'b0;
                        if (ReadLatency == 1) begin
                            rd_state  <= RD_RESP;
                            r_valid_q <= 1'b1;
                        end else begin
                            rd_state <= RD_WAIT;
                            rd_cnt   <= CntW'(ReadLatency - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    rd_cnt <= rd_cnt - 1'b1;
                    if (rd_cnt == CntW'(1)) begin
                        rd_state  <= RD_RESP;
                        r_valid_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (r_ready_i) begin
                        rd_state   <= RD_IDLE;
                        r_valid_q  <= 1'b0;
                        ar_ready_q <= 1'b1;
                    end
                end
                default: begin
                    rd_state   <= RD_IDLE;
                    r_valid_q  <= 1'b0;
                    ar_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_idma_lite_mem_responder.sv
// Bench for idma_lite_mem_responder: directed scenarios plus random traffic against a word-array reference model.
module tb_idma_lite_mem_responder;
    localparam int          NW   = 16;
    localparam int          RL   = 3;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [2:0]  aw_prot = '0, ar_prot = '0;
    logic [3:0]  w_strb = '0;
    logic        aw_valid = 1'b0, w_valid = 1'b0, ar_valid = 1'b0;
    logic        b_ready = 1'b1, r_ready = 1'b1;
    logic        aw_ready, w_ready, ar_ready, b_valid, r_valid;
    logic [1:0]  b_resp, r_resp;
    logic [31:0] r_data;

    idma_lite_mem_responder #(
        .DataWidth(32), .AddrWidth(32), .NumWords(NW), .BaseAddr(BASE), .ReadLatency(RL)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .aw_addr_i(aw_addr), .aw_prot_i(aw_prot), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
        .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
        .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
        .ar_addr_i(ar_addr), .ar_prot_i(ar_prot), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    bit rnd   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: plain word array, addressed by the documented rules
    logic [31:0] model_mem [NW];

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(NW * 4));
    endfunction

    function automatic int widx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE) >> 2;
        return int'(off % NW);
    endfunction

    function automatic bit acc_ok(input logic [31:0] a);
`ifdef IDMA_LITE_MEM_RANGE_CHECK_EN
        return in_rng(a);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        return acc_ok(a) ? 2'b00 : 2'b10;
    endfunction

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        int          due;
    } rexp_t;

    logic [31:0] aw_q [$];
    logic [35:0] w_q  [$];
    logic [1:0]  b_q  [$];
    rexp_t       r_q  [$];

    // Monitor: the commit of the oldest pending write is visible when a fresh B appears.
    initial begin
        logic        prev_bv, prev_bhs, prev_rv, prev_rhs;
        logic [31:0] a;
        logic [35:0] wd;
        rexp_t       e;
        prev_bv = 0; prev_bhs = 0; prev_rv = 0; prev_rhs = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (b_valid && (!prev_bv || prev_bhs)) begin
                    if (aw_q.size() == 0 || w_q.size() == 0) begin
                        flag("b_spurious");
                    end else begin
                        a  = aw_q.pop_front();
                        wd = w_q.pop_front();
                        if (acc_ok(a))
                            for (int i = 0; i < 4; i++)
                                if (wd[32+i]) model_mem[widx(a)][8*i +: 8] = wd[8*i +: 8];
                        b_q.push_back(exp_resp(a));
                    end
                end
                if (b_valid && b_q.size() > 0) begin
                    check("b_resp", 64'(b_resp), 64'(b_q[0]));
                    if (b_ready) void'(b_q.pop_front());
                end
                if (r_valid) begin
                    if (r_q.size() == 0) begin
                        flag("r_spurious");
                    end else begin
                        if (!prev_rv || prev_rhs) check("r_latency", 64'(cyc), 64'(r_q[0].due));
                        check("r_data", 64'(r_data), 64'(r_q[0].data));
                        check("r_resp", 64'(r_resp), 64'(r_q[0].resp));
                        if (r_ready) void'(r_q.pop_front());
                    end
                end
                if (aw_valid && aw_ready) aw_q.push_back(aw_addr);
                if (w_valid && w_ready) w_q.push_back({w_strb, w_data});
                if (ar_valid && ar_ready) begin
                    e.data = acc_ok(ar_addr) ? model_mem[widx(ar_addr)] : 32'h0;
                    e.resp = exp_resp(ar_addr);
                    e.due  = cyc + RL;
                    r_q.push_back(e);
                end
                prev_bv  = b_valid;
                prev_bhs = b_valid && b_ready;
                prev_rv  = r_valid;
                prev_rhs = r_valid && r_ready;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rnd) begin
            b_ready = ($urandom_range(0, 3) != 0);
            r_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Drivers: called at posedge+1, return at posedge+1 after the handshake cycle
    task automatic send_aw(input logic [31:0] a, output int hs);
        aw_addr = a; aw_prot = 3'($urandom); aw_valid = 1'b1; hs = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (aw_ready) begin hs = cyc; break; end
        end
        @(posedge clk); #1;
        aw_valid = 1'b0;
        if (hs < 0) flag("aw_timeout");
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int hs);
        w_data = d; w_strb = s; w_valid = 1'b1; hs = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (w_ready) begin hs = cyc; break; end
        end
        @(posedge clk); #1;
        w_valid = 1'b0;
        if (hs < 0) flag("w_timeout");
    endtask

    task automatic send_ar(input logic [31:0] a, output int hs);
        ar_addr = a; ar_prot = 3'($urandom); ar_valid = 1'b1; hs = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ar_ready) begin hs = cyc; break; end
        end
        @(posedge clk); #1;
        ar_valid = 1'b0;
        if (hs < 0) flag("ar_timeout");
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int h1, h2;
        fork
            send_aw(a, h1);
            send_w(d, s, h2);
        join
    endtask

    task automatic do_read(input logic [31:0] a);
        int h;
        send_ar(a, h);
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (aw_q.size() == 0 && w_q.size() == 0 && b_q.size() == 0 && r_q.size() == 0
                && !b_valid && !r_valid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) flag("drain_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int h, h2, bc;
        repeat (3) @(negedge clk);
        check("rst_aw_ready", 64'(aw_ready), 64'd1);
        check("rst_w_ready", 64'(w_ready), 64'd1);
        check("rst_ar_ready", 64'(ar_ready), 64'd1);
        check("rst_b_valid", 64'(b_valid), 64'd0);
        check("rst_b_resp", 64'(b_resp), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_resp", 64'(r_resp), 64'd0);
        check("rst_r_data", 64'(r_data), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < NW; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF);
        wait_idle();

        // Full write then read-back, then a partial-strobe overwrite
        do_write(BASE + 32'h10, 32'hDEADBEEF, 4'hF);
        wait_idle();
        do_read(BASE + 32'h10);
        wait_idle();
        do_write(BASE + 32'h10, 32'h0000_1234, 4'h3);
        wait_idle();
        do_read(BASE + 32'h12);
        wait_idle();

        // W arrives well ahead of AW
        send_w(32'hCAFEF00D, 4'hF, h);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("w_ready_held", 64'(w_ready), 64'd0);
            check("b_early", 64'(b_valid), 64'd0);
        end
        @(posedge clk); #1;
        send_aw(BASE + 32'h20, h2);
        bc = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b_valid) begin bc = cyc; break; end
        end
        check("b_after_aw", 64'(bc - h2), 64'd2);
        @(posedge clk); #1;
        wait_idle();

        // B stalled with a second pair to the same word queued behind it
        b_ready = 1'b0;
        do_write(BASE + 32'h24, 32'h1111_1111, 4'hF);
        do_write(BASE + 32'h24, 32'h2222_2222, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("aw_ready_stall", 64'(aw_ready), 64'd0);
            check("w_ready_stall", 64'(w_ready), 64'd0);
            check("b_valid_stall", 64'(b_valid), 64'd1);
        end
        @(posedge clk); #1;
        do_read(BASE + 32'h24);
        for (int i = 0; i < 20 && r_q.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
        b_ready = 1'b1;
        @(negedge clk);
        check("b_first_hs", 64'(b_valid), 64'd1);
        @(negedge clk);
        check("b_second_next", 64'(b_valid), 64'd1);
        @(posedge clk); #1;
        wait_idle();
        do_read(BASE + 32'h24);
        wait_idle();

        // Read held by r_ready low
        r_ready = 1'b0;
        send_ar(BASE + 32'h10, h);
        for (int k = 1; k <= RL + 3; k++) begin
            @(negedge clk);
            check("ar_ready_busy", 64'(ar_ready), 64'd0);
            check("r_valid_seq", 64'(r_valid), 64'(k >= RL));
        end
        @(posedge clk); #1;
        r_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("ar_ready_back", 64'(ar_ready), 64'd1);
        check("r_valid_done", 64'(r_valid), 64'd0);
        @(posedge clk); #1;

        // One word past the top of the window
        do_write(BASE + 32'(NW * 4), 32'hA5A5_5A5A, 4'hF);
        wait_idle();
        do_read(BASE);
        wait_idle();

        // Random concurrent traffic
        rnd = 1'b1;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    logic [31:0] a, d;
                    logic [3:0]  s;
                    int          d1, d2, x1, x2;
                    a  = BASE - 32'd16 + 32'($urandom_range(0, NW * 4 + 31));
                    d  = $urandom;
                    s  = 4'($urandom);
                    d1 = $urandom_range(0, 3);
                    d2 = $urandom_range(0, 3);
                    fork
                        begin repeat (d1) begin @(posedge clk); #1; end send_aw(a, x1); end
                        begin repeat (d2) begin @(posedge clk); #1; end send_w(d, s, x2); end
                    join
                end
            end
            begin
                for (int n = 0; n < 100; n++) begin
                    int x;
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    send_ar(BASE - 32'd16 + 32'($urandom_range(0, NW * 4 + 31)), x);
                end
            end
        join
        rnd = 1'b0;
        @(posedge clk); #1;
        b_ready = 1'b1;
        r_ready = 1'b1;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
